// File: rtl/spi_command_parser_pkg.sv
// ----------------------------------------------------------------------------
// spi_parser_pkg : opcodes, header/status field positions and parser states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package spi_parser_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_MOVE   = 8'h10;
  localparam logic [7:0] OP_STATUS = 8'h20;

  localparam int HDR_OP_LSB   = 0;
  localparam int HDR_OP_MSB   = 7;
  localparam int HDR_ADDR_LSB = 8;

  localparam int ST_ERR_LSB  = 0;
  localparam int ST_ERR_MSB  = 7;
  localparam int ST_OVF_BIT  = 8;
  localparam int ST_TMO_BIT  = 9;
  localparam int ST_MV_BIT   = 10;
  localparam int ST_WAIT_BIT = 11;

  typedef enum logic [0:0] {
    ST_IDLE         = 1'b0,
    ST_WAIT_PAYLOAD = 1'b1
  } state_t;

  function automatic logic [63:0] build_status(
    input logic [7:0] err_cnt,
    input logic       ovf,
    input logic       tmo,
    input logic       mv,
    input logic       waiting
  );
    logic [63:0] s;
    s                        = '0;
    s[ST_ERR_MSB:ST_ERR_LSB] = err_cnt;
    s[ST_OVF_BIT]            = ovf;
    s[ST_TMO_BIT]            = tmo;
    s[ST_MV_BIT]             = mv;
    s[ST_WAIT_BIT]           = waiting;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_command_parser_if.sv
// ----------------------------------------------------------------------------
// spi_command_parser_if : word receiver, config port and move port bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface spi_command_parser_if #(
  parameter int WORD_BITS = 64,
  parameter int ADDR_BITS = 4
);
  logic                 word_received;
  logic [WORD_BITS-1:0] word_data_received;
  logic [WORD_BITS-1:0] word_send_data;
  logic                 cfg_wr_en;
  logic [ADDR_BITS-1:0] cfg_wr_addr;
  logic [WORD_BITS-1:0] cfg_wr_data;
  logic [ADDR_BITS-1:0] cfg_rd_addr;
  logic [WORD_BITS-1:0] cfg_rd_data;
  logic [WORD_BITS-1:0] move_data;
  logic                 move_valid;
  logic                 move_ready;
  logic                 parser_error;

  modport slave (
    input  word_received, word_data_received, cfg_rd_data, move_ready,
    output word_send_data, cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_addr,
           move_data, move_valid, parser_error
  );

  modport master (
    output word_received, word_data_received, cfg_rd_data, move_ready,
    input  word_send_data, cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_addr,
           move_data, move_valid, parser_error
  );
endinterface

`default_nettype wire

// File: rtl/spi_command_parser_move_slot.sv
// ----------------------------------------------------------------------------
// parser_move_slot : single-entry valid/ready holding register, sticky overflow
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module parser_move_slot #(
  parameter int WORD_BITS = 64
) (
  input  wire                  clk,
  input  wire                  reset,
  input  wire                  load,
  input  wire [WORD_BITS-1:0]  load_data,
  input  wire                  ready,
  input  wire                  clear_ovf,
  output logic [WORD_BITS-1:0] data,
  output logic                 valid,
  output logic                 busy,
  output logic                 overflow
);

  // Slot is free when empty or being drained on this same edge.
  assign busy = valid & ~ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (load && !busy) begin
        data  <= load_data;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (clear_ovf) begin
        overflow <= 1'b0;
      end else if (load && busy) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_command_parser.sv
// ----------------------------------------------------------------------------
// spi_command_parser : decodes SPI header/payload words; optional payload
// timeout under SPI_PARSER_TIMEOUT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_command_parser
  import spi_parser_pkg::*;
#(
  parameter int WORD_BITS      = 64,
  parameter int ADDR_BITS      = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input wire                  clk,
  input wire                  reset,
  spi_command_parser_if.slave bus
);

  logic                 r_word_d;
  state_t               r_state;
  logic                 r_pend_move;
  logic [ADDR_BITS-1:0] r_addr;
  logic [WORD_BITS-1:0] r_send;
  logic                 r_wr_en;
  logic [ADDR_BITS-1:0] r_wr_addr;
  logic [WORD_BITS-1:0] r_wr_data;
  logic [7:0]           r_err_cnt;
  logic                 r_tmo;
  logic                 r_error;

  logic                 w_strobe;
  logic [7:0]           w_opcode;
  logic                 w_hdr;
  logic                 w_payload;
  logic                 w_bad_op;
  logic                 w_status_clr;
  logic                 w_move_req;
  logic                 w_move_drop;
  logic                 w_timeout;
  logic                 w_err_event;
  logic                 w_slot_valid;
  logic                 w_slot_busy;
  logic                 w_slot_ovf;
  logic [WORD_BITS-1:0] w_slot_data;

  assign w_strobe     = bus.word_received & ~r_word_d;
  assign w_opcode     = bus.word_data_received[HDR_OP_MSB:HDR_OP_LSB];
  assign w_hdr        = w_strobe && (r_state == ST_IDLE);
  assign w_payload    = w_strobe && (r_state == ST_WAIT_PAYLOAD);
  assign w_bad_op     = w_hdr && !(w_opcode inside {OP_NOP, OP_WRITE, OP_READ, OP_MOVE, OP_STATUS});
  assign w_status_clr = w_hdr && (w_opcode == OP_STATUS);
  assign w_move_req   = w_payload && r_pend_move;
  assign w_move_drop  = w_move_req && w_slot_busy;
  assign w_err_event  = w_bad_op | w_move_drop | w_timeout;

  assign bus.cfg_rd_addr    = bus.word_data_received[HDR_ADDR_LSB +: ADDR_BITS];
  assign bus.word_send_data = r_send;
  assign bus.cfg_wr_en      = r_wr_en;
  assign bus.cfg_wr_addr    = r_wr_addr;
  assign bus.cfg_wr_data    = r_wr_data;
  assign bus.move_data      = w_slot_data;
  assign bus.move_valid     = w_slot_valid;
  assign bus.parser_error   = r_error;

  parser_move_slot #(
    .WORD_BITS(WORD_BITS)
  ) u_move_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (w_move_req),
    .load_data (bus.word_data_received),
    .ready     (bus.move_ready),
    .clear_ovf (w_status_clr),
    .data      (w_slot_data),
    .valid     (w_slot_valid),
    .busy      (w_slot_busy),
    .overflow  (w_slot_ovf)
  );

`ifdef SPI_PARSER_TIMEOUT_EN
  localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

  logic [c_TMO_W-1:0] r_tmo_cnt;

  // A strobe on the expiry cycle wins: it is taken as the payload.
  assign w_timeout = (r_state == ST_WAIT_PAYLOAD) && !w_strobe && (r_tmo_cnt == c_TMO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else if ((r_state != ST_WAIT_PAYLOAD) || w_strobe || w_timeout) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word_d    <= 1'b0;
      r_state     <= ST_IDLE;
      r_pend_move <= 1'b0;
      r_addr      <= '0;
      r_send      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_err_cnt   <= '0;
      r_tmo       <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_word_d <= bus.word_received;
      r_wr_en  <= 1'b0;
      r_error  <= w_err_event;

      // STATUS read clears the counters even if an error lands on the same edge.
      if (w_status_clr) begin
        r_err_cnt <= '0;
        r_tmo     <= 1'b0;
      end else begin
        if (w_err_event && (r_err_cnt != 8'hFF)) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
        if (w_timeout) begin
          r_tmo <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (w_hdr) begin
            case (w_opcode)
              OP_WRITE: begin
                r_addr      <= bus.word_data_received[HDR_ADDR_LSB +: ADDR_BITS];
                r_pend_move <= 1'b0;
                r_state     <= ST_WAIT_PAYLOAD;
              end
              OP_MOVE: begin
                r_pend_move <= 1'b1;
                r_state     <= ST_WAIT_PAYLOAD;
              end
              OP_READ:   r_send <= bus.cfg_rd_data;
              OP_STATUS: r_send <= build_status(r_err_cnt, w_slot_ovf, r_tmo, w_slot_valid,
                                                1'b0);
              default:   r_send <= '0;
            endcase
          end
        end
        ST_WAIT_PAYLOAD: begin
          if (w_payload) begin
            r_state <= ST_IDLE;
            if (!r_pend_move) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_addr;
              r_wr_data <= bus.word_data_received;
            end
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
